// File: rtl/fpu_addsub_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : fpu_addsub_rr_scheduler
// Brief   : Round-robin issue scheduler sharing one pipelined FPU add/sub unit
//           among NUM_REQ lanes, with per-lane credits and tag-based returns.
// Revision: 1.0 - initial release
// ============================================================================
module fpu_addsub_rr_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 2,
  parameter int MAX_OUTST = 8,
  parameter int CNT_W     = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
  input  logic [NUM_REQ-1:0]        i_req_op,
  output logic                      o_fpu_valid,
  input  logic                      i_fpu_ready,
  output logic [DATA_W-1:0]         o_fpu_a,
  output logic [DATA_W-1:0]         o_fpu_b,
  output logic                      o_fpu_op,
  output logic [TAG_W-1:0]          o_fpu_tag,
  input  logic                      i_fpu_res_valid,
  input  logic [DATA_W-1:0]         i_fpu_res_data,
  input  logic [TAG_W-1:0]          i_fpu_res_tag,
  output logic [NUM_REQ-1:0]        o_res_valid,
  output logic [DATA_W-1:0]         o_res_data,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam logic [TAG_W-1:0] c_last_lane = TAG_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] c_max_cred  = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] c_one_cred  = CNT_W'(1);

  logic [CNT_W-1:0]   credit_q [NUM_REQ];
  logic [TAG_W-1:0]   rr_ptr_q;
  logic               fpu_valid_q;
  logic [DATA_W-1:0]  fpu_a_q;
  logic [DATA_W-1:0]  fpu_b_q;
  logic               fpu_op_q;
  logic [TAG_W-1:0]   fpu_tag_q;
  logic [NUM_REQ-1:0] res_valid_q;
  logic [DATA_W-1:0]  res_data_q;
  logic               err_q;

  logic [DATA_W-1:0]  w_lane_a [NUM_REQ];
  logic [DATA_W-1:0]  w_lane_b [NUM_REQ];
  logic [NUM_REQ-1:0] w_eligible;
  logic [NUM_REQ-1:0] w_underflow;
  logic [NUM_REQ-1:0] w_cred_nz;
  logic               w_grant_found;
  logic [TAG_W-1:0]   w_grant_idx;
  logic               w_slot_free;
  logic               w_accept;
  logic               w_tag_ok;
  logic               w_err_set;

  assign w_slot_free = !fpu_valid_q || i_fpu_ready;
  assign w_accept    = w_grant_found && w_slot_free && !i_rst;
  assign w_tag_ok    = int'(i_fpu_res_tag) < NUM_REQ;
  assign w_err_set   = i_fpu_res_valid && (!w_tag_ok || (|w_underflow));

  // Scan lanes starting at the round-robin pointer; first eligible wins.
  always_comb begin
    logic [TAG_W-1:0] cand;
    cand          = '0;
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = TAG_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!w_grant_found && w_eligible[cand]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = cand;
      end
    end
  end

  assign o_req_ready = w_accept ? (NUM_REQ'(1) << w_grant_idx) : '0;

  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
      logic w_inc;
      logic w_dec;

      assign w_lane_a[k]    = i_req_a[k*DATA_W +: DATA_W];
      assign w_lane_b[k]    = i_req_b[k*DATA_W +: DATA_W];
      assign w_eligible[k]  = i_req_valid[k] && (credit_q[k] < c_max_cred);
      assign w_inc          = w_accept && (w_grant_idx == TAG_W'(k));
      assign w_dec          = i_fpu_res_valid && w_tag_ok && (i_fpu_res_tag == TAG_W'(k));
      // A return with nothing outstanding is a protocol error; the count never wraps.
      assign w_underflow[k] = w_dec && !w_inc && (credit_q[k] == '0);
      assign w_cred_nz[k]   = |credit_q[k];

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          credit_q[k] <= '0;
        end else if (w_inc && !w_dec) begin
          credit_q[k] <= credit_q[k] + c_one_cred;
        end else if (w_dec && !w_inc && (credit_q[k] != '0)) begin
          credit_q[k] <= credit_q[k] - c_one_cred;
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fpu_valid_q <= 1'b0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      fpu_op_q    <= 1'b0;
      fpu_tag_q   <= '0;
      rr_ptr_q    <= '0;
    end else if (w_accept) begin
      fpu_valid_q <= 1'b1;
      fpu_a_q     <= w_lane_a[w_grant_idx];
      fpu_b_q     <= w_lane_b[w_grant_idx];
      fpu_op_q    <= i_req_op[w_grant_idx];
      fpu_tag_q   <= w_grant_idx;
      rr_ptr_q    <= (w_grant_idx == c_last_lane) ? '0 : w_grant_idx + TAG_W'(1);
    end else if (w_slot_free) begin
      fpu_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      res_valid_q <= '0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      res_valid_q <= (i_fpu_res_valid && w_tag_ok) ? (NUM_REQ'(1) << i_fpu_res_tag) : '0;
      if (i_fpu_res_valid) begin
        res_data_q <= i_fpu_res_data;
      end
      if (w_err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign o_fpu_valid = fpu_valid_q;
  assign o_fpu_a     = fpu_a_q;
  assign o_fpu_b     = fpu_b_q;
  assign o_fpu_op    = fpu_op_q;
  assign o_fpu_tag   = fpu_tag_q;
  assign o_res_valid = res_valid_q;
  assign o_res_data  = res_data_q;
  assign o_busy      = (|w_cred_nz) || fpu_valid_q;
  assign o_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_addsub_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpu_addsub_rr_scheduler
// Brief   : Randomised and directed bench for fpu_addsub_rr_scheduler against
//           a lane-credit/queue reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fpu_addsub_rr_scheduler;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 32;
  localparam int TAG_W     = 2;
  localparam int MAX_OUTST = 8;
  localparam int CNT_W     = 4;

  logic                      i_clk = 1'b0;
  logic                      i_rst = 1'b1;
  logic [NUM_REQ-1:0]        i_req_valid = '0;
  logic [NUM_REQ-1:0]        o_req_ready;
  logic [NUM_REQ*DATA_W-1:0] i_req_a = '0;
  logic [NUM_REQ*DATA_W-1:0] i_req_b = '0;
  logic [NUM_REQ-1:0]        i_req_op = '0;
  logic                      o_fpu_valid;
  logic                      i_fpu_ready = 1'b1;
  logic [DATA_W-1:0]         o_fpu_a;
  logic [DATA_W-1:0]         o_fpu_b;
  logic                      o_fpu_op;
  logic [TAG_W-1:0]          o_fpu_tag;
  logic                      i_fpu_res_valid = 1'b0;
  logic [DATA_W-1:0]         i_fpu_res_data = '0;
  logic [TAG_W-1:0]          i_fpu_res_tag = '0;
  logic [NUM_REQ-1:0]        o_res_valid;
  logic [DATA_W-1:0]         o_res_data;
  logic                      o_busy;
  logic                      o_err;

  fpu_addsub_rr_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TAG_W(TAG_W),
    .MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_op(i_req_op),
    .o_fpu_valid(o_fpu_valid), .i_fpu_ready(i_fpu_ready),
    .o_fpu_a(o_fpu_a), .o_fpu_b(o_fpu_b), .o_fpu_op(o_fpu_op), .o_fpu_tag(o_fpu_tag),
    .i_fpu_res_valid(i_fpu_res_valid), .i_fpu_res_data(i_fpu_res_data),
    .i_fpu_res_tag(i_fpu_res_tag),
    .o_res_valid(o_res_valid), .o_res_data(o_res_data),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: outstanding count per lane, next lane in turn, issue slot.
  int                 m_cred [NUM_REQ];
  int                 m_ptr = 0;
  logic               m_fv = 1'b0;
  logic [DATA_W-1:0]  m_fa = '0;
  logic [DATA_W-1:0]  m_fb = '0;
  logic               m_fop = 1'b0;
  int                 m_ftag = 0;
  logic [NUM_REQ-1:0] m_rv = '0;
  logic [DATA_W-1:0]  m_rd = '0;
  logic               m_err = 1'b0;

  function automatic logic [NUM_REQ-1:0] m_ready();
    logic [NUM_REQ-1:0] r;
    r = '0;
    if (i_rst || (m_fv && !i_fpu_ready)) return r;
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = (m_ptr + i) % NUM_REQ;
      if (i_req_valid[k] && m_cred[k] < MAX_OUTST) begin
        r[k] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic m_busy();
    logic b;
    b = m_fv;
    for (int k = 0; k < NUM_REQ; k++) if (m_cred[k] != 0) b = 1'b1;
    return b;
  endfunction

  task automatic tick();
    logic [NUM_REQ-1:0] rdy;
    int g;
    int t;
    rdy = m_ready();
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) if (rdy[k]) g = k;
    @(posedge i_clk);
    if (i_rst) begin
      for (int k = 0; k < NUM_REQ; k++) m_cred[k] = 0;
      m_ptr = 0; m_fv = 1'b0; m_fa = '0; m_fb = '0; m_fop = 1'b0; m_ftag = 0;
      m_rv = '0; m_rd = '0; m_err = 1'b0;
    end else begin
      if (g >= 0) begin
        m_fv = 1'b1;
        m_fa = i_req_a[g*DATA_W +: DATA_W];
        m_fb = i_req_b[g*DATA_W +: DATA_W];
        m_fop = i_req_op[g];
        m_ftag = g;
        m_ptr = (g + 1) % NUM_REQ;
        m_cred[g]++;
      end else if (!m_fv || i_fpu_ready) begin
        m_fv = 1'b0;
      end
      t = i_fpu_res_valid ? int'(i_fpu_res_tag) : -1;
      m_rv = '0;
      if (t >= NUM_REQ) m_err = 1'b1;
      else if (t >= 0) begin
        m_rv[t] = 1'b1;
        if (m_cred[t] == 0) m_err = 1'b1;
        else m_cred[t]--;
      end
      if (i_fpu_res_valid) m_rd = i_fpu_res_data;
    end
    #1;
  endtask

  task automatic rand_operands();
    for (int k = 0; k < NUM_REQ; k++) begin
      i_req_a[k*DATA_W +: DATA_W] = $urandom;
      i_req_b[k*DATA_W +: DATA_W] = $urandom;
    end
    i_req_op = NUM_REQ'($urandom);
  endtask

  task automatic drain();
    i_req_valid = '0;
    i_fpu_ready = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      while (m_cred[k] > 0) begin
        i_fpu_res_valid = 1'b1;
        i_fpu_res_tag   = TAG_W'(k);
        i_fpu_res_data  = $urandom;
        tick();
        n_vec++;
        if (o_res_valid !== m_rv || o_res_data !== m_rd) begin
          n_err++;
          $display("FAIL drain_return: got strobe %b data %h, expected %b %h", o_res_valid, o_res_data, m_rv, m_rd);
        end
      end
    end
    i_fpu_res_valid = 1'b0;
    tick();
    n_vec++;
    if (o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL drain_idle: o_busy got %b expected 0", o_busy);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_req_valid = '1;
    i_fpu_ready = 1'b1;
    rand_operands();
    tick();
    tick();
    n_vec++;
    if (o_req_ready !== '0 || o_fpu_valid !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0 || o_res_valid !== '0) begin
      n_err++;
      $display("FAIL reset: ready %b fpu_valid %b busy %b err %b res_valid %b, expected all 0",
               o_req_ready, o_fpu_valid, o_busy, o_err, o_res_valid);
    end
    i_rst = 1'b0;
    i_req_valid = '0;
    tick();
  endtask

  task automatic test_fairness();
    logic [DATA_W-1:0] exp_a;
    i_fpu_ready = 1'b1;
    i_req_valid = '1;
    for (int j = 0; j < 12; j++) begin
      rand_operands();
      exp_a = i_req_a[(j % NUM_REQ)*DATA_W +: DATA_W];
      #1;
      n_vec++;
      if (o_req_ready !== NUM_REQ'(1 << (j % NUM_REQ))) begin
        n_err++;
        $display("FAIL fair_ready[%0d]: got %b expected %b", j, o_req_ready, NUM_REQ'(1 << (j % NUM_REQ)));
      end
      tick();
      n_vec++;
      if (o_fpu_valid !== 1'b1 || int'(o_fpu_tag) != (j % NUM_REQ) || o_fpu_a !== exp_a) begin
        n_err++;
        $display("FAIL fair_issue[%0d]: valid %b tag %0d a %h, expected 1 %0d %h", j, o_fpu_valid, o_fpu_tag, o_fpu_a, j % NUM_REQ, exp_a);
      end
    end
    drain();
  endtask

  task automatic test_stall();
    logic [DATA_W-1:0] hb;
    logic              hop;
    logic [DATA_W-1:0] a2;
    i_fpu_ready = 1'b1;
    rand_operands();
    i_req_a[1*DATA_W +: DATA_W] = 32'h3F80_0000;
    hb  = i_req_b[1*DATA_W +: DATA_W];
    hop = i_req_op[1];
    i_req_valid = 4'b0010;
    tick();
    i_req_valid = 4'b0110;
    rand_operands();
    a2 = i_req_a[2*DATA_W +: DATA_W];
    i_fpu_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      n_vec++;
      if (o_req_ready !== '0) begin
        n_err++;
        $display("FAIL stall_ready[%0d]: got %b expected 0000", j, o_req_ready);
      end
      tick();
      n_vec++;
      if (o_fpu_valid !== 1'b1 || o_fpu_tag !== 2'd1 || o_fpu_a !== 32'h3F80_0000 || o_fpu_b !== hb || o_fpu_op !== hop) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: valid %b tag %0d a %h b %h op %b, expected 1 1 3f800000 %h %b",
                 j, o_fpu_valid, o_fpu_tag, o_fpu_a, o_fpu_b, o_fpu_op, hb, hop);
      end
    end
    i_fpu_ready = 1'b1;
    #1;
    n_vec++;
    if (o_req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL stall_resume_ready: got %b expected 0100", o_req_ready);
    end
    tick();
    n_vec++;
    if (o_fpu_valid !== 1'b1 || o_fpu_tag !== 2'd2 || o_fpu_a !== a2) begin
      n_err++;
      $display("FAIL stall_resume_issue: valid %b tag %0d a %h, expected 1 2 %h", o_fpu_valid, o_fpu_tag, o_fpu_a, a2);
    end
    drain();
  endtask

  task automatic test_credit_limit();
    int acc;
    i_fpu_ready = 1'b1;
    i_req_valid = 4'b0001;
    acc = 0;
    for (int j = 0; j < 12; j++) begin
      rand_operands();
      #1;
      if (o_req_ready[0]) acc++;
      n_vec++;
      if (o_req_ready !== m_ready()) begin
        n_err++;
        $display("FAIL limit_ready[%0d]: got %b expected %b", j, o_req_ready, m_ready());
      end
      tick();
    end
    n_vec++;
    if (acc != MAX_OUTST || o_req_ready !== '0) begin
      n_err++;
      $display("FAIL limit_count: accepts %0d ready %b, expected %0d 0000", acc, o_req_ready, MAX_OUTST);
    end
    i_fpu_res_valid = 1'b1;
    i_fpu_res_tag   = 2'd0;
    i_fpu_res_data  = $urandom;
    #1;
    n_vec++;
    if (o_req_ready !== '0) begin
      n_err++;
      $display("FAIL limit_same_cycle: got %b expected 0000", o_req_ready);
    end
    tick();
    i_fpu_res_valid = 1'b0;
    acc = 0;
    for (int j = 0; j < 4; j++) begin
      #1;
      if (o_req_ready[0]) acc++;
      tick();
    end
    n_vec++;
    if (acc != 1 || o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL limit_refill: accepts %0d busy %b, expected 1 1", acc, o_busy);
    end
    drain();
  endtask

  task automatic test_simultaneous();
    logic [DATA_W-1:0] d;
    i_fpu_ready = 1'b1;
    rand_operands();
    i_req_valid = 4'b1000;
    tick();
    rand_operands();
    d = $urandom;
    i_fpu_res_valid = 1'b1;
    i_fpu_res_tag   = 2'd3;
    i_fpu_res_data  = d;
    #1;
    n_vec++;
    if (o_req_ready !== 4'b1000) begin
      n_err++;
      $display("FAIL simul_ready: got %b expected 1000", o_req_ready);
    end
    tick();
    i_fpu_res_valid = 1'b0;
    i_req_valid = '0;
    n_vec++;
    if (o_res_valid !== 4'b1000 || o_res_data !== d) begin
      n_err++;
      $display("FAIL simul_strobe: got %b %h expected 1000 %h", o_res_valid, o_res_data, d);
    end
    tick();
    n_vec++;
    if (o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL simul_credit_kept: busy got %b expected 1", o_busy);
    end
    i_fpu_res_valid = 1'b1;
    i_fpu_res_data  = $urandom;
    tick();
    i_fpu_res_valid = 1'b0;
    tick();
    n_vec++;
    if (o_busy !== 1'b0 || o_err !== 1'b0) begin
      n_err++;
      $display("FAIL simul_credit_drain: busy %b err %b expected 0 0", o_busy, o_err);
    end
  endtask

  task automatic test_errors();
    logic [DATA_W-1:0] d;
    i_fpu_ready = 1'b1;
    rand_operands();
    i_req_valid = 4'b0010;
    tick();
    i_req_valid = '0;
    d = $urandom;
    i_fpu_res_valid = 1'b1;
    i_fpu_res_tag   = 2'd2;
    i_fpu_res_data  = d;
    tick();
    n_vec++;
    if (o_res_valid !== 4'b0100 || o_res_data !== d || o_err !== 1'b1) begin
      n_err++;
      $display("FAIL err_zero_credit: strobe %b data %h err %b, expected 0100 %h 1", o_res_valid, o_res_data, o_err, d);
    end
    i_fpu_res_tag = 2'd1;
    tick();
    i_fpu_res_valid = 1'b0;
    n_vec++;
    if (o_res_valid !== 4'b0010 || o_err !== 1'b1) begin
      n_err++;
      $display("FAIL err_other_lane: strobe %b err %b, expected 0010 1", o_res_valid, o_err);
    end
    tick();
    tick();
    n_vec++;
    if (o_busy !== 1'b0 || o_err !== 1'b1 || o_res_valid !== '0) begin
      n_err++;
      $display("FAIL err_sticky: busy %b err %b strobe %b, expected 0 1 0000", o_busy, o_err, o_res_valid);
    end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    n_vec++;
    if (o_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clear: got %b expected 0", o_err);
    end
  endtask

  task automatic test_random();
    int cand[$];
    for (int j = 0; j < 400; j++) begin
      rand_operands();
      i_req_valid = NUM_REQ'($urandom);
      i_fpu_ready = ($urandom % 4) != 0;
      i_rst = ($urandom % 150) == 0;
      cand.delete();
      for (int k = 0; k < NUM_REQ; k++) if (m_cred[k] > 0) cand.push_back(k);
      i_fpu_res_valid = 1'b0;
      i_fpu_res_data  = $urandom;
      if (($urandom % 64) == 0) begin
        i_fpu_res_valid = 1'b1;
        i_fpu_res_tag   = TAG_W'($urandom);
      end else if (cand.size() > 0 && ($urandom % 2) == 0) begin
        i_fpu_res_valid = 1'b1;
        i_fpu_res_tag   = TAG_W'(cand[$urandom % cand.size()]);
      end
      #1;
      n_vec++;
      if (o_req_ready !== m_ready()) begin
        n_err++;
        $display("FAIL rnd_ready[%0d]: got %b expected %b", j, o_req_ready, m_ready());
      end
      tick();
      n_vec++;
      if (o_fpu_valid !== m_fv || (m_fv && (o_fpu_a !== m_fa || o_fpu_b !== m_fb || o_fpu_op !== m_fop || int'(o_fpu_tag) != m_ftag))) begin
        n_err++;
        $display("FAIL rnd_issue[%0d]: v %b a %h b %h op %b tag %0d, expected %b %h %h %b %0d",
                 j, o_fpu_valid, o_fpu_a, o_fpu_b, o_fpu_op, o_fpu_tag, m_fv, m_fa, m_fb, m_fop, m_ftag);
      end
      n_vec++;
      if (o_res_valid !== m_rv || (m_rv != '0 && o_res_data !== m_rd)) begin
        n_err++;
        $display("FAIL rnd_result[%0d]: got %b %h expected %b %h", j, o_res_valid, o_res_data, m_rv, m_rd);
      end
      n_vec++;
      if (o_busy !== m_busy() || o_err !== m_err) begin
        n_err++;
        $display("FAIL rnd_status[%0d]: busy %b err %b expected %b %b", j, o_busy, o_err, m_busy(), m_err);
      end
    end
    i_rst = 1'b0;
    i_fpu_res_valid = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NUM_REQ; k++) m_cred[k] = 0;
    test_reset();
    test_fairness();
    test_stall();
    test_credit_limit();
    test_simultaneous();
    test_errors();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
